mem_responder: RTL and testbench

Byte-wide memory responder sitting on the far side of the memory controller's `mem_a`/`mem_dout`/`mem_wr`/`mem_din` bus. Serves RAM reads and writes with fixed 1-cycle read latency. Decodes the I/O window: writes to the I/O data port go into a TX FIFO that generates the controller's `io_buffer_full` back-pressure. Serves as the simulation and FPGA memory/I-O endpoint for the CPU core.

---
 rtl/mem_responder.sv | 103 ++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-wide RAM and I/O endpoint with TX FIFO back-pressure
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_pop,
  output logic        halt,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] FULL_MARK = (PW+1)'(FIFO_DEPTH - 2);

  logic [7:0] ram      [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] fifo_mem [0:FIFO_DEPTH-1];

  logic [PW-1:0]         wptr, rptr;
  logic [PW:0]           count, next_count;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  io_sel, port0, port4;
  logic                  ram_wr, push, pop, push_ok;
  logic                  fifo_empty, fifo_full;
  logic [7:0]            io_rd_data;
  logic                  unused_addr;

  assign idx         = mem_a[ADDR_WIDTH-1:0];
  assign io_sel      = (mem_a[17:16] == 2'b11);
  assign port0       = (mem_a[2:0] == 3'd0);
  assign port4       = (mem_a[2:0] == 3'd4);
  assign unused_addr = ^mem_a[31:18];

  // Reset in the same cycle cancels whatever the bus was asking for.
  assign ram_wr = rst_n && rdy && mem_wr && !io_sel;
  assign push   = rst_n && rdy && mem_wr && io_sel && port0;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == DEPTH_C);
  assign pop         = !fifo_empty && io_tx_ready;
  // A simultaneous pop frees a slot, so a push at full still lands.
  assign push_ok     = push && (!fifo_full || pop);
  assign io_tx_valid = !fifo_empty;
  assign io_tx_data  = fifo_mem[rptr];

  always_comb begin
    next_count = count;
    case ({push_ok, pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  always_comb begin
    io_rd_data = 8'h00;
    if (port0) io_rd_data = io_rx_valid ? io_rx_data : 8'h00;
    else if (port4) io_rd_data = {7'b0, fifo_empty};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_din        <= 8'h00;
      count          <= '0;
      wptr           <= '0;
      rptr           <= '0;
      io_buffer_full <= 1'b0;
      io_rx_pop      <= 1'b0;
      halt           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      count          <= next_count;
      io_buffer_full <= (next_count >= FULL_MARK);
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      io_rx_pop <= rdy && io_sel && !mem_wr && port0 && io_rx_valid;
      if (rdy) begin
        if (!io_sel) mem_din <= ram[idx];
        else if (!mem_wr) mem_din <= io_rd_data;
        if (io_sel && mem_wr && port4) halt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr)  ram[idx]       <= mem_dout;
    if (push_ok) fifo_mem[wptr] <= mem_dout;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid, io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid, io_rx_pop, halt, overflow;

  int n_assert = 0;
  int n_fail   = 0;

  mem_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full),
    .io_tx_data(io_tx_data), .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready),
    .io_rx_data(io_rx_data), .io_rx_valid(io_rx_valid), .io_rx_pop(io_rx_pop),
    .halt(halt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic wr);
    mem_a = a; mem_dout = d; mem_wr = wr;
    step();
    mem_a = 32'h0; mem_dout = 8'h00; mem_wr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; mem_a = 32'h0; mem_dout = 8'h00; mem_wr = 1'b0;
    io_tx_ready = 1'b0; io_rx_data = 8'h00; io_rx_valid = 1'b0;
    step(); step();
    chk("rst_mem_din", mem_din, 0);
    chk("rst_full", io_buffer_full, 0);
    chk("rst_tx_valid", io_tx_valid, 0);
    chk("rst_rx_pop", io_rx_pop, 0);
    chk("rst_halt", halt, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // RAM write then read, then back-to-back reads
    bus(32'h10, 8'hA5, 1'b1);
    bus(32'h10, 8'h00, 1'b0);
    chk("ram_wr_rd", mem_din, 8'hA5);
    bus(32'h11, 8'h11, 1'b1);
    bus(32'h12, 8'h22, 1'b1);
    bus(32'h13, 8'h33, 1'b1);
    bus(32'h10, 8'h00, 1'b0); chk("b2b_10", mem_din, 8'hA5);
    bus(32'h11, 8'h00, 1'b0); chk("b2b_11", mem_din, 8'h11);
    bus(32'h12, 8'h00, 1'b0); chk("b2b_12", mem_din, 8'h22);
    bus(32'h13, 8'h00, 1'b0); chk("b2b_13", mem_din, 8'h33);
    bus(32'h20010, 8'h5A, 1'b1);
    bus(32'h10, 8'h00, 1'b0); chk("ram_alias", mem_din, 8'h5A);
    bus(32'h10, 8'h77, 1'b1); chk("rd_before_wr", mem_din, 8'h5A);
    bus(32'h10, 8'h00, 1'b0); chk("wr_after_rbw", mem_din, 8'h77);

    // TX fill with downstream stalled
    for (int i = 0; i < 5; i++) bus(32'h30000, 8'hB0 + 8'(i), 1'b1);
    chk("fill5_valid", io_tx_valid, 1);
    chk("fill5_head", io_tx_data, 8'hB0);
    chk("fill5_full", io_buffer_full, 0);
    bus(32'h30000, 8'hB5, 1'b1);
    chk("fill6_full", io_buffer_full, 1);
    bus(32'h30000, 8'hB6, 1'b1);
    bus(32'h30000, 8'hB7, 1'b1);
    chk("fill8_ovf", overflow, 0);
    bus(32'h30004, 8'h00, 1'b0);
    chk("port4_nonempty", mem_din, 0);
    bus(32'h30000, 8'hB8, 1'b1);
    chk("fill9_ovf", overflow, 1);
    chk("fill9_full", io_buffer_full, 1);

    // Drain in order
    io_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", io_tx_data, 8'hB0 + i);
      step();
    end
    chk("drain_valid", io_tx_valid, 0);
    chk("drain_full", io_buffer_full, 0);
    bus(32'h30004, 8'h00, 1'b0);
    chk("port4_empty", mem_din, 1);

    // Wraparound: second batch crosses index 7 -> 0
    for (int r = 0; r < 2; r++) begin
      io_tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) bus(32'h30000, 8'hC0 + 8'(16*r + i), 1'b1);
      io_tx_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        chk("wrap_data", io_tx_data, 8'hC0 + 16*r + i);
        step();
      end
      chk("wrap_valid", io_tx_valid, 0);
    end

    // Simultaneous push and pop at count 6
    io_tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) bus(32'h30000, 8'hE0 + 8'(i), 1'b1);
    chk("sim_pre_full", io_buffer_full, 1);
    io_tx_ready = 1'b1;
    bus(32'h30000, 8'hE6, 1'b1);
    chk("sim_full", io_buffer_full, 1);
    for (int i = 0; i < 6; i++) begin
      chk("sim_drain", io_tx_data, 8'hE1 + i);
      step();
    end
    chk("sim_count6", io_tx_valid, 0);
    io_tx_ready = 1'b0;
    bus(32'h30000, 8'hF0, 1'b1);
    chk("one_valid", io_tx_valid, 1);
    chk("one_data", io_tx_data, 8'hF0);
    io_tx_ready = 1'b1;
    step();
    chk("one_count", io_tx_valid, 0);

    // I/O reads and halt
    io_rx_valid = 1'b1; io_rx_data = 8'h41;
    bus(32'h30000, 8'h00, 1'b0);
    io_rx_valid = 1'b0;
    chk("rx_data", mem_din, 8'h41);
    chk("rx_pop_hi", io_rx_pop, 1);
    step();
    chk("rx_pop_lo", io_rx_pop, 0);
    bus(32'h30000, 8'h00, 1'b0);
    chk("rx_none_data", mem_din, 0);
    chk("rx_none_pop", io_rx_pop, 0);
    chk("halt_pre", halt, 0);
    bus(32'h30004, 8'h01, 1'b1);
    chk("halt_set", halt, 1);
    step(); step();
    chk("halt_sticky", halt, 1);

    // rdy=0 blocks bus side but drain continues
    io_tx_ready = 1'b0;
    bus(32'h20, 8'h12, 1'b1);
    bus(32'h30000, 8'h61, 1'b1);
    bus(32'h30000, 8'h62, 1'b1);
    bus(32'h20, 8'h00, 1'b0);
    chk("rdy_pre", mem_din, 8'h12);
    rdy = 1'b0;
    bus(32'h20, 8'h99, 1'b1);
    bus(32'h30, 8'h00, 1'b0);
    chk("rdy_hold", mem_din, 8'h12);
    io_tx_ready = 1'b1;
    mem_a = 32'h30000; mem_dout = 8'h63; mem_wr = 1'b1;
    step();
    chk("rdy_drain", io_tx_data, 8'h62);
    step();
    chk("rdy_nopush", io_tx_valid, 0);
    io_rx_valid = 1'b1; mem_wr = 1'b0;
    step();
    chk("rdy_nopop", io_rx_pop, 0);
    io_rx_valid = 1'b0;
    rdy = 1'b1; io_tx_ready = 1'b0;
    bus(32'h20, 8'h00, 1'b0);
    chk("rdy_ram", mem_din, 8'h12);

    // Reset mid-drain, with a pending rx read in the reset cycle
    for (int i = 0; i < 4; i++) bus(32'h30000, 8'h70 + 8'(i), 1'b1);
    io_tx_ready = 1'b1;
    step();
    chk("mid_drain", io_tx_data, 8'h71);
    rst_n = 1'b0; io_rx_valid = 1'b1; io_rx_data = 8'h55;
    bus(32'h30000, 8'h00, 1'b0);
    rst_n = 1'b1; io_rx_valid = 1'b0;
    chk("rst2_valid", io_tx_valid, 0);
    chk("rst2_full", io_buffer_full, 0);
    chk("rst2_mem_din", mem_din, 0);
    chk("rst2_rx_pop", io_rx_pop, 0);
    chk("rst2_halt", halt, 0);
    chk("rst2_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
